// File: rtl/button_conditioner_ice_if.sv
// rtl/button_conditioner_ice_if.sv - button pin and conditioned event bundle
// Slave side is the conditioner; master side drives the raw pins and consumes events.
interface button_conditioner_ice_if #(
  parameter int N_BUTTONS = 3
) ();
  logic [N_BUTTONS-1:0] i_btn_raw;
  logic [N_BUTTONS-1:0] o_level;
  logic [N_BUTTONS-1:0] o_press;
  logic [N_BUTTONS-1:0] o_release;
  logic [N_BUTTONS-1:0] o_long;

  modport master (
    output i_btn_raw,
    input  o_level,
    input  o_press,
    input  o_release,
    input  o_long
  );

  modport slave (
    input  i_btn_raw,
    output o_level,
    output o_press,
    output o_release,
    output o_long
  );
endinterface

// File: rtl/button_conditioner_ice.sv
// rtl/button_conditioner_ice.sv - per-button synchroniser, debounce FSM and press/release/long pulses
// Optional long-press detection is enabled by defining BTN_LONG_PRESS_EN.
module button_conditioner_ice #(
  parameter int N_BUTTONS         = 3,
  parameter int DEBOUNCE_CYCLES   = 10000,
  parameter int LONG_PRESS_CYCLES = 1000000,
  parameter int CNT_W             = $clog2(LONG_PRESS_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      res,
  button_conditioner_ice_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_PRESS_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
`endif

  logic [N_BUTTONS-1:0] r_sync1;
  logic [N_BUTTONS-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (res) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  genvar g;
  for (g = 0; g < N_BUTTONS; g++) begin : g_ch
    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic             w_long_nxt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             r_long;

    always_ff @(posedge clk) begin
      if (res) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end

    always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_sync2[g]) begin
            w_state_nxt = ST_PRESS_WAIT;
            w_cnt_nxt   = '0;
          end
        end
        ST_PRESS_WAIT: begin
          if (!r_sync2[g]) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
            w_press_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        ST_PRESSED: begin
          if (!r_sync2[g]) begin
            w_state_nxt = ST_RELEASE_WAIT;
            w_cnt_nxt   = '0;
          end
`ifdef BTN_LONG_PRESS_EN
          // Saturating at LONG_MAX guarantees a single o_long per stable hold.
          else if (r_cnt < LONG_MAX) begin
            w_cnt_nxt  = r_cnt + CNT_W'(1);
            w_long_nxt = (r_cnt == LONG_LAST);
          end
`endif
        end
        ST_RELEASE_WAIT: begin
          if (r_sync2[g]) begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end else if (r_cnt == DEB_LAST) begin
            w_state_nxt   = ST_IDLE;
            w_cnt_nxt     = '0;
            w_release_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (res) begin
        r_level   <= 1'b0;
        r_press   <= 1'b0;
        r_release <= 1'b0;
        r_long    <= 1'b0;
      end else begin
        r_level   <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
        r_press   <= w_press_nxt;
        r_release <= w_release_nxt;
        r_long    <= w_long_nxt;
      end
    end

    assign bus.o_level[g]   = r_level;
    assign bus.o_press[g]   = r_press;
    assign bus.o_release[g] = r_release;
    assign bus.o_long[g]    = r_long;
  end

endmodule

// File: doc/button_conditioner_ice.md
# button_conditioner_ice

Per-button input conditioner for the iCEstick stopwatch build, sitting between the board pins (start/stop, lap, reset buttons) and the `ui_in` bits of `tt_um_faramire_stopwatch`. Each raw button passes through a two-flop synchroniser, then a per-button debounce state machine. The block produces a clean debounced level, single-cycle press and release pulses and, optionally, a long-press pulse. It runs on the divided 1 MHz `clk_tt` domain.

## Interface
- `N_BUTTONS`, 3: number of independent button channels.
- `DEBOUNCE_CYCLES`, 10000: consecutive stable cycles required to accept a level change (10 ms at 1 MHz); legal range ≥1.
- `LONG_PRESS_CYCLES`, 1000000: cycles in PRESSED before `o_long` fires (1 s); must be > 0.
- `CNT_W`, `$clog2(LONG_PRESS_CYCLES+1)`: counter width; must also hold `DEBOUNCE_CYCLES`.

Ports:
- `clk`  in  1  block clock (1 MHz `clk_tt`).
- `res`  in  1  synchronous, active-high reset.
- `i_btn_raw`  in  N_BUTTONS  raw asynchronous button pins, active-high (1 = pressed).
- `o_level`  out  N_BUTTONS  debounced level.
- `o_press`  out  N_BUTTONS  one-cycle pulse on accepted press.
- `o_release`  out  N_BUTTONS  one-cycle pulse on accepted release.
- `o_long`  out  N_BUTTONS  one-cycle pulse on long press (tied 0 without `BTN_LONG_PRESS_EN`).

## Operation
- Synchroniser: `sync1 <= i_btn_raw`, `sync2 <= sync1`. The FSM sees only `sync2`.
- Per-channel FSM, with its own `cnt` (CNT_W bits):
  - IDLE: `sync2`=1 → PRESS_WAIT, `cnt`=0.
  - PRESS_WAIT:
    - `sync2`=0 → IDLE, `cnt`=0 (glitch rejected, no pulse).
    - `sync2`=1 and `cnt`==DEBOUNCE_CYCLES-1 → PRESSED, `cnt`=0, `o_press`=1 next cycle.
    - Otherwise `cnt`+1.
  - PRESSED: `sync2`=0 → RELEASE_WAIT, `cnt`=0. Otherwise, long-press counting (see Configuration).
  - RELEASE_WAIT:
    - `sync2`=1 → PRESSED, `cnt`=0. The long-press count restarts; no second `o_press`.
    - `sync2`=0 and `cnt`==DEBOUNCE_CYCLES-1 → IDLE, `o_release`=1 next cycle.
    - Otherwise `cnt`+1.
- `o_level`=1 exactly in PRESSED and RELEASE_WAIT.
- All outputs are registered.
- Channels are fully independent. Pulses on several channels in the same cycle are legal and must all appear.
- Counters never wrap. In PRESSED the counter saturates at LONG_PRESS_CYCLES.

## Timing
- Reset (`res`=1 at a rising edge):
  - Clears `sync1`, `sync2`, all FSMs to IDLE, all `cnt` to 0.
  - Clears all outputs (`o_level`, `o_press`, `o_release`, `o_long`) to 0 on that edge.
  - Reset overrides all other activity, including mid-debounce and mid-press; no pulse is emitted because of reset.
- Raw input held high at reset release: treated as a fresh press and debounced normally.
- Press latency: raw high sampled at edge 0 → `o_press` high after edge DEBOUNCE_CYCLES+2, for exactly one cycle. `o_level` rises on the same edge.
- Release latency: symmetric. `o_release` is high after edge DEBOUNCE_CYCLES+2 counted from the first low sample; `o_level` falls on the same edge.
- Any bounce shorter than DEBOUNCE_CYCLES stable cycles produces no pulse and no level change.

## Configuration
- `BTN_LONG_PRESS_EN` defined:
  - In PRESSED, `cnt` increments each cycle while `sync2`=1.
  - On reaching LONG_PRESS_CYCLES, `o_long` pulses for one cycle, and `cnt` then holds.
  - At most one `o_long` per press.
  - A bounce into RELEASE_WAIT and back resets the count.
- `BTN_LONG_PRESS_EN` undefined:
  - No long-press counting logic.
  - `o_long` is constant 0.
  - `cnt` width may shrink to `$clog2(DEBOUNCE_CYCLES+1)`.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=20, N_BUTTONS=3.
- Clean press on btn0 sampled at edge 0, held → `o_press[0]` high only after edge 6, `o_level[0]`=1 from edge 6; no other outputs change.
- Bounce: btn1 high for 3 cycles, low, then high steadily → single `o_press[1]`, 6 edges after the final rising sample.
- Release of held btn0 → `o_release[0]` one cycle, 6 edges after the first low sample; `o_level[0]`=0 on the same edge.
- Simultaneous clean press on all three channels → `o_press`=3'b111 for exactly one cycle.
- With `BTN_LONG_PRESS_EN`: btn2 held for 40 cycles after acceptance → exactly one `o_long[2]`, 20 edges after `o_press[2]`. Without the macro, `o_long` stays 0.
- `res` asserted for 1 cycle while btn0 is in PRESSED and btn1 in PRESS_WAIT → all outputs 0 on the next edge, no pulses. With both held, `o_press` on both again after the full debounce latency.
